// File: rtl/signal_decoder.sv
// -----------------------------------------------------------------------------
// signal_decoder
//
// Recovers timing from the toggling square wave produced by the toggle
// receiver. signal_in is synchronized and every transition becomes a one-cycle
// edge_pulse. While enabled, the module measures the gap in clocks between
// consecutive edges. It declares lock after LOCK_N consecutive gaps fall within
// HALF_PERIOD +/- TOL. It raises a sticky loss-of-signal flag when no edge
// arrives within TIMEOUT clocks.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-low
//   en           in   block enable; low forces IDLE
//   signal_in    in   asynchronous toggling input
//   edge_pulse   out  one-cycle strobe per detected edge
//   level        out  synchronized level of signal_in
//   half_period  out  [CNT_W] last measured gap in clocks
//   period_valid out  one-cycle strobe when half_period updates
//   locked       out  high while gaps keep matching HALF_PERIOD
//   timeout_err  out  sticky loss-of-signal flag
// -----------------------------------------------------------------------------
module signal_decoder #(
  parameter int CNT_W       = 8,
  parameter int HALF_PERIOD = 25,
  parameter int TOL         = 1,
  parameter int LOCK_N      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             signal_in,
  output logic             edge_pulse,
  output logic             level,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout_err
);

  localparam int MW = $clog2(LOCK_N + 1);

  // The match window is compared one bit wider than the counter. The lower
  // bound is clamped to 0 so a small HALF_PERIOD cannot wrap around.
  localparam logic [CNT_W:0] MATCH_HI = (CNT_W+1)'(HALF_PERIOD + TOL);
  localparam logic [CNT_W:0] MATCH_LO = (HALF_PERIOD > TOL) ?
                                        (CNT_W+1)'(HALF_PERIOD - TOL) :
                                        (CNT_W+1)'(0);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_ONE   = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_N_C  = MW'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, level_dly_q;
  logic             edge_pulse_q;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic [MW-1:0]    match_q, match_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_err_q, timeout_err_d;

  logic             edge_det;
  logic             gap_match;
  logic [CNT_W:0]   gap_ext;

  // An edge is any change of the synchronized level. The FSM reacts to it
  // combinationally, so period_valid and half_period register in the same
  // clock as edge_pulse.
  assign edge_det  = sync2_q ^ level_dly_q;
  assign gap_ext   = {1'b0, gap_q};
  assign gap_match = (gap_ext >= MATCH_LO) && (gap_ext <= MATCH_HI);

  always_comb begin
    state_d        = state_q;
    gap_d          = gap_q;
    match_d        = match_q;
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;
    timeout_err_d  = timeout_err_q;

    if (!en) begin
      state_d = IDLE;
      gap_d   = '0;
      match_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          gap_d = '0;
          if (edge_det) begin
            // Reference edge only: there is no previous edge to measure from.
            state_d       = MEASURE;
            gap_d         = GAP_ONE;
            match_d       = '0;
            timeout_err_d = 1'b0;
          end
        end
        MEASURE, LOCKED: begin
          // An edge takes priority over a timeout in the same cycle.
          if (edge_det) begin
            half_period_d  = gap_q;
            period_valid_d = 1'b1;
            gap_d          = GAP_ONE;
            if (gap_match) begin
              if (match_q < LOCK_N_C) begin
                match_d = match_q + 1'b1;
              end
              if (match_d == LOCK_N_C) begin
                state_d = LOCKED;
              end
            end else begin
              match_d = '0;
              state_d = MEASURE;
            end
          end else if (gap_q == TIMEOUT_C) begin
            state_d       = IDLE;
            gap_d         = '0;
            match_d       = '0;
            timeout_err_d = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
          match_d = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      level_dly_q    <= 1'b0;
      edge_pulse_q   <= 1'b0;
      state_q        <= IDLE;
      gap_q          <= '0;
      match_q        <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      sync1_q        <= signal_in;
      sync2_q        <= sync1_q;
      level_dly_q    <= sync2_q;
      edge_pulse_q   <= edge_det;
      state_q        <= state_d;
      gap_q          <= gap_d;
      match_q        <= match_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign level        = sync2_q;
  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_signal_decoder.sv
// -----------------------------------------------------------------------------
// tb_signal_decoder
//
// Directed bench for signal_decoder with default parameters. signal_in is
// toggled one time unit after a rising edge. Outputs are sampled one time unit
// after rising edges. A toggle becomes visible on edge_pulse, period_valid,
// half_period and locked exactly three rising edges later.
// -----------------------------------------------------------------------------
module tb_signal_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       signal_in = 1'b0;
  logic       edge_pulse;
  logic       level;
  logic [7:0] half_period;
  logic       period_valid;
  logic       locked;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  signal_decoder #(
    .CNT_W(8), .HALF_PERIOD(25), .TOL(1), .LOCK_N(4), .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .signal_in(signal_in),
    .edge_pulse(edge_pulse),
    .level(level),
    .half_period(half_period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   gap;
    logic pv;
    int   hp;
    logic lk;
    logic te;
  } vec_t;

  vec_t vecs[24];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Toggle signal_in 'gap' clocks after the previous toggle.
  // Then check the edge's results three clocks later.
  task automatic do_edge(input string tag, input int gap, input logic exp_pv,
                         input int exp_hp, input logic exp_lk, input logic exp_te);
    repeat (gap - 3) step();
    signal_in = ~signal_in;
    step();
    step();
    chk({tag, " ep_early"}, 32'(edge_pulse), 32'd0);
    step();
    chk({tag, " edge_pulse"},   32'(edge_pulse),   32'd1);
    chk({tag, " period_valid"}, 32'(period_valid), 32'(exp_pv));
    chk({tag, " half_period"},  32'(half_period),  32'(exp_hp));
    chk({tag, " locked"},       32'(locked),       32'(exp_lk));
    chk({tag, " timeout_err"},  32'(timeout_err),  32'(exp_te));
    $display("edge %s gap=%0d hp=%0d pv=%0d locked=%0d terr=%0d",
             tag, gap, half_period, period_valid, locked, timeout_err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " edge_pulse"},   32'(edge_pulse),   32'd0);
    chk({tag, " level"},        32'(level),        32'd0);
    chk({tag, " half_period"},  32'(half_period),  32'd0);
    chk({tag, " period_valid"}, 32'(period_valid), 32'd0);
    chk({tag, " locked"},       32'(locked),       32'd0);
    chk({tag, " timeout_err"},  32'(timeout_err),  32'd0);
    $display("reset check %s", tag);
  endtask

  initial begin
    // gap, pv, hp, locked, timeout_err
    vecs[0]  = '{5,  1'b0, 0,  1'b0, 1'b0};  // reference edge
    vecs[1]  = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[2]  = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[3]  = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[4]  = '{25, 1'b1, 25, 1'b1, 1'b0};  // fourth match -> lock
    vecs[5]  = '{25, 1'b1, 25, 1'b1, 1'b0};
    vecs[6]  = '{27, 1'b1, 27, 1'b0, 1'b0};  // just above window
    vecs[7]  = '{24, 1'b1, 24, 1'b0, 1'b0};  // lower window edge
    vecs[8]  = '{26, 1'b1, 26, 1'b0, 1'b0};  // upper window edge
    vecs[9]  = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[10] = '{24, 1'b1, 24, 1'b1, 1'b0};
    vecs[11] = '{8,  1'b1, 8,  1'b0, 1'b0};  // fast toggling
    vecs[12] = '{8,  1'b1, 8,  1'b0, 1'b0};
    vecs[13] = '{8,  1'b1, 8,  1'b0, 1'b0};
    vecs[14] = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[15] = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[16] = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[17] = '{25, 1'b1, 25, 1'b1, 1'b0};
    vecs[18] = '{23, 1'b1, 23, 1'b0, 1'b0};  // just below window
    vecs[19] = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[20] = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[21] = '{25, 1'b1, 25, 1'b0, 1'b0};
    vecs[22] = '{25, 1'b1, 25, 1'b1, 1'b0};
    vecs[23] = '{25, 1'b1, 25, 1'b1, 1'b0};

    // Reset state
    reset = 1'b0;
    en    = 1'b1;
    repeat (3) step();
    chk_all_zero("por");
    reset = 1'b1;
    step();

    // Table-driven gap stream
    for (int i = 0; i < 24; i++) begin
      do_edge($sformatf("vec%0d", i), vecs[i].gap, vecs[i].pv, vecs[i].hp,
              vecs[i].lk, vecs[i].te);
    end

    // Loss of signal: freeze while locked; timeout fires 64 clocks after the last edge
    repeat (63) step();
    chk("tmo pre terr",   32'(timeout_err), 32'd0);
    chk("tmo pre locked", 32'(locked),      32'd1);
    step();
    chk("tmo terr",   32'(timeout_err), 32'd1);
    chk("tmo locked", 32'(locked),      32'd0);
    $display("timeout after 64 idle clocks terr=%0d locked=%0d", timeout_err, locked);
    do_edge("reacq", 10, 1'b0, 25, 1'b0, 1'b0);

    // Edge coinciding with the timeout cycle is measured, not a timeout
    do_edge("tmo_edge", 64, 1'b1, 64, 1'b0, 1'b0);
    do_edge("relock1", 25, 1'b1, 25, 1'b0, 1'b0);
    do_edge("relock2", 25, 1'b1, 25, 1'b0, 1'b0);
    do_edge("relock3", 25, 1'b1, 25, 1'b0, 1'b0);
    do_edge("relock4", 25, 1'b1, 25, 1'b1, 1'b0);

    // One-clock reset while locked; relock needs a fresh reference plus four gaps
    repeat (5) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_all_zero("midlock");
    do_edge("rst_ref", 10, 1'b0, 0,  1'b0, 1'b0);
    do_edge("rst_g1",  25, 1'b1, 25, 1'b0, 1'b0);
    do_edge("rst_g2",  25, 1'b1, 25, 1'b0, 1'b0);
    do_edge("rst_g3",  25, 1'b1, 25, 1'b0, 1'b0);
    do_edge("rst_g4",  25, 1'b1, 25, 1'b1, 1'b0);

    // Enable low: lock drops, half_period holds, edges still pulse
    step();
    en = 1'b0;
    step();
    chk("en_low locked", 32'(locked),      32'd0);
    chk("en_low hp",     32'(half_period), 32'd25);
    $display("en low locked=%0d hp=%0d", locked, half_period);
    do_edge("en_low_edge", 10, 1'b0, 25, 1'b0, 1'b0);
    en = 1'b1;
    do_edge("en_ref", 10, 1'b0, 25, 1'b0, 1'b0);
    do_edge("en_g1",  25, 1'b1, 25, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
